assert_ctrl_monitor: RTL and testbench

- Synthesizable, parametrised successor to the simulation-only "signal must stay low after reset" check with global on/off/freeze/thaw control.
- Monitors N_CH independent check signals; each must be 0 while its channel is armed.
- Per-channel control arrives over a valid/ready command port: on, off, freeze, thaw, clear.
- Violations are recorded in saturating per-channel counters, sticky flags, a first-failure capture register and a maskable interrupt; sits beside any datapath as an in-silicon checker.

---
 rtl/assert_ctrl_monitor.sv | 133 +++++++++++++
 tb/tb_assert_ctrl_monitor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/assert_ctrl_monitor.sv
// In-silicon "must stay low while armed" checker for N_CH signals, with per-channel
// on/off/freeze/thaw/clear control, saturating fail counters, first-fail capture and irq.
module assert_ctrl_monitor #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 8,
    parameter int ARM_DLY = 2,
    parameter int INIT_ON = 0,
    parameter int ID_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       chk_sig,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [N_CH-1:0]       cmd_mask,
    input  logic [N_CH-1:0]       irq_en,
    output logic [2*N_CH-1:0]     ch_state,
    output logic [N_CH-1:0]       fail_sticky,
    output logic [N_CH*CNT_W-1:0] fail_cnt,
    output logic                  first_fail_vld,
    output logic [ID_W-1:0]       first_fail_id,
    output logic                  irq
);

    localparam int AW = (ARM_DLY > 0) ? $clog2(ARM_DLY + 1) : 1;
    localparam logic [AW-1:0]    ARM_INIT = AW'(ARM_DLY);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {ST_OFF, ST_ARMING, ST_ON, ST_FROZEN} st_e;

    st_e              state_q [N_CH];
    logic [AW-1:0]    arm_q   [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]  sticky_q, sticky_d;
    logic             ffv_q, ffv_d;
    logic [ID_W-1:0]  ffid_q, ffid_d;
    logic             irq_q, rdy_q;
    logic             acc;
    logic [N_CH-1:0]  clr, vrec;
    logic             held;
    logic [ID_W-1:0]  low_id;

    // Sampling uses the pre-edge state; a CLEAR on the same channel overrides the sample.
    always_comb begin
        acc    = cmd_valid & rdy_q;
        clr    = (acc && cmd_op == 3'd5) ? cmd_mask : '0;
        vrec   = '0;
        held   = 1'b0;
        low_id = '0;
        for (int i = 0; i < N_CH; i++) begin
            vrec[i] = chk_sig[i] && (state_q[i] == ST_ON) && !clr[i];
            if (clr[i])
                cnt_d[i] = '0;
            else if (vrec[i] && cnt_q[i] != CNT_MAX)
                cnt_d[i] = cnt_q[i] + 1'b1;
            else
                cnt_d[i] = cnt_q[i];
            if (ffid_q == ID_W'(i))
                held = ffv_q && !clr[i];
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (vrec[i])
                low_id = ID_W'(i);
        end
        sticky_d = (sticky_q & ~clr) | vrec;
        ffv_d    = held | (|vrec);
        ffid_d   = (!held && (|vrec)) ? low_id : ffid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            sticky_q <= '0;
            ffv_q    <= 1'b0;
            ffid_q   <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= (INIT_ON != 0) ? ST_ON : ST_OFF;
                arm_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            rdy_q    <= 1'b1;
            sticky_q <= sticky_d;
            ffv_q    <= ffv_d;
            ffid_q   <= ffid_d;
            irq_q    <= |(sticky_d & irq_en);
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                // Countdown runs unless a command below overrides it.
                if (state_q[i] == ST_ARMING) begin
                    if (arm_q[i] <= AW'(1)) begin
                        state_q[i] <= ST_ON;
                        arm_q[i]   <= '0;
                    end else begin
                        arm_q[i] <= arm_q[i] - 1'b1;
                    end
                end
                if (acc && cmd_mask[i]) begin
                    case (cmd_op)
                        3'd1: if (state_q[i] == ST_OFF) begin
                            state_q[i] <= (ARM_DLY == 0) ? ST_ON : ST_ARMING;
                            arm_q[i]   <= ARM_INIT;
                        end
                        3'd2: begin
                            state_q[i] <= ST_OFF;
                            arm_q[i]   <= '0;
                        end
                        3'd3: if (state_q[i] == ST_ON) state_q[i] <= ST_FROZEN;
                        3'd4: if (state_q[i] == ST_FROZEN) state_q[i] <= ST_ON;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_state[2*i +: 2]        = state_q[i];
            fail_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign cmd_ready      = rdy_q;
    assign fail_sticky    = sticky_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_id  = ffid_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_assert_ctrl_monitor.sv
// Table-driven bench for assert_ctrl_monitor (N_CH=4, CNT_W=3, ARM_DLY=2, INIT_ON=0).
module tb_assert_ctrl_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  chk_sig;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_mask;
    logic [3:0]  irq_en;
    logic [7:0]  ch_state;
    logic [3:0]  fail_sticky;
    logic [11:0] fail_cnt;
    logic        first_fail_vld;
    logic [1:0]  first_fail_id;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    assert_ctrl_monitor #(.N_CH(4), .CNT_W(3), .ARM_DLY(2), .INIT_ON(0)) dut (
        .clk(clk), .rst_n(rst_n), .chk_sig(chk_sig),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_mask(cmd_mask), .irq_en(irq_en), .ch_state(ch_state),
        .fail_sticky(fail_sticky), .fail_cnt(fail_cnt),
        .first_fail_vld(first_fail_vld), .first_fail_id(first_fail_id), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [2:0]  op;
        logic [3:0]  mask;
        logic [3:0]  chk;
        logic [7:0]  st;
        logic [3:0]  sticky;
        logic [11:0] cnt;
        logic        ffv;
        logic [1:0]  ffid;
        logic        irq;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic cv, input logic [2:0] op, input logic [3:0] mask,
                                input logic [3:0] chk, input logic [7:0] st,
                                input logic [3:0] sticky, input logic [11:0] cnt,
                                input logic ffv, input logic [1:0] ffid, input logic irq);
        vec_t v;
        v.cv = cv; v.op = op; v.mask = mask; v.chk = chk; v.st = st;
        v.sticky = sticky; v.cnt = cnt; v.ffv = ffv; v.ffid = ffid; v.irq = irq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_out(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".state"},  32'(ch_state),       32'(e.st));
        check({tag, ".sticky"}, 32'(fail_sticky),    32'(e.sticky));
        check({tag, ".cnt"},    32'(fail_cnt),       32'(e.cnt));
        check({tag, ".ffv"},    32'(first_fail_vld), 32'(e.ffv));
        if (e.ffv)
            check({tag, ".ffid"}, 32'(first_fail_id), 32'(e.ffid));
        check({tag, ".irq"},    32'(irq),            32'(e.irq));
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        cmd_valid = v.cv;
        cmd_op    = v.op;
        cmd_mask  = v.mask;
        chk_sig   = v.chk;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".rdy"},    32'(cmd_ready),      32'd0);
        check({tag, ".state"},  32'(ch_state),       32'd0);
        check({tag, ".sticky"}, 32'(fail_sticky),    32'd0);
        check({tag, ".cnt"},    32'(fail_cnt),       32'd0);
        check({tag, ".ffv"},    32'(first_fail_vld), 32'd0);
        check({tag, ".ffid"},   32'(first_fail_id),  32'd0);
        check({tag, ".irq"},    32'(irq),            32'd0);
    endtask

    initial begin
        // cv op mask chk | state sticky cnt ffv ffid irq
        tbl.push_back(mk(0, 0, 4'h0, 4'h0, 8'h00, 4'h0, 12'h000, 0, 0, 0)); // idle
        tbl.push_back(mk(1, 1, 4'h1, 4'h0, 8'h01, 4'h0, 12'h000, 0, 0, 0)); // ON ch0 -> ARMING
        tbl.push_back(mk(0, 0, 4'h0, 4'h1, 8'h01, 4'h0, 12'h000, 0, 0, 0)); // arming: not counted
        tbl.push_back(mk(0, 0, 4'h0, 4'h0, 8'h02, 4'h0, 12'h000, 0, 0, 0)); // ON at k+2
        tbl.push_back(mk(0, 0, 4'h0, 4'h3, 8'h02, 4'h1, 12'h001, 1, 0, 1)); // ch0 counts, ch1 OFF
        tbl.push_back(mk(1, 5, 4'hF, 4'h0, 8'h02, 4'h0, 12'h000, 0, 0, 0)); // clear all
        tbl.push_back(mk(1, 1, 4'hE, 4'h0, 8'h56, 4'h0, 12'h000, 0, 0, 0)); // arm ch1..3
        tbl.push_back(mk(0, 0, 4'h0, 4'h0, 8'h56, 4'h0, 12'h000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 4'h0, 8'hAA, 4'h0, 12'h000, 0, 0, 0)); // all ON
        tbl.push_back(mk(0, 0, 4'h0, 4'hA, 8'hAA, 4'hA, 12'h208, 1, 1, 1)); // ch1,ch3 fail
        tbl.push_back(mk(0, 0, 4'h0, 4'h1, 8'hAA, 4'hB, 12'h209, 1, 1, 1)); // first id kept
        tbl.push_back(mk(1, 5, 4'hF, 4'h0, 8'hAA, 4'h0, 12'h000, 0, 0, 0));
        tbl.push_back(mk(1, 5, 4'h1, 4'h3, 8'hAA, 4'h2, 12'h008, 1, 1, 1)); // clear beats ch0
        tbl.push_back(mk(1, 5, 4'h2, 4'h4, 8'hAA, 4'h4, 12'h040, 1, 2, 1)); // freed + recaptured
        tbl.push_back(mk(1, 5, 4'hF, 4'h0, 8'hAA, 4'h0, 12'h000, 0, 0, 0));
        tbl.push_back(mk(1, 3, 4'h4, 4'h4, 8'hBA, 4'h4, 12'h040, 1, 2, 1)); // freeze, sample counts
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 4'h0, 4'h4, 8'hBA, 4'h4, 12'h040, 1, 2, 1)); // frozen
        tbl.push_back(mk(1, 4, 4'h4, 4'h4, 8'hAA, 4'h4, 12'h040, 1, 2, 1)); // thaw
        tbl.push_back(mk(0, 0, 4'h0, 4'h4, 8'hAA, 4'h4, 12'h080, 1, 2, 1)); // resumes
        tbl.push_back(mk(1, 2, 4'h4, 4'h4, 8'h8A, 4'h4, 12'h0C0, 1, 2, 1)); // OFF, still counted
        tbl.push_back(mk(0, 0, 4'h0, 4'h4, 8'h8A, 4'h4, 12'h0C0, 1, 2, 1)); // OFF: ignored
        tbl.push_back(mk(1, 5, 4'hF, 4'h0, 8'h8A, 4'h0, 12'h000, 0, 0, 0));

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_mask = 4'h0;
        chk_sig = 4'h0; irq_en = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(cmd_ready), 32'd1);

        foreach (tbl[i])
            apply(tbl[i], $sformatf("vec%0d", i));

        // Saturation of the 3-bit counter on ch0.
        for (int i = 0; i < 10; i++)
            apply(mk(0, 0, 4'h0, 4'h1, 8'h8A, 4'h1, 12'((i + 1 > 7) ? 7 : i + 1), 1, 0, 1),
                  $sformatf("sat%0d", i));

        irq_en = 4'hE;
        apply(mk(0, 0, 4'h0, 4'h0, 8'h8A, 4'h1, 12'h007, 1, 0, 0), "irq_masked");
        irq_en = 4'hF;
        apply(mk(0, 0, 4'h0, 4'h0, 8'h8A, 4'h1, 12'h007, 1, 0, 1), "irq_unmasked");

        // Asynchronous reset between edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_async", 32'(cmd_ready), 32'd1);
        check("state_after_async", 32'(ch_state), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
